uart_rx_param: RTL and testbench

- Parametrised next-generation UART receiver for the SoC serial path.
- Supports configurable data width, runtime parity (none/even/odd), 1 or 2 stop bits, and 3-sample majority voting at mid-bit.
- Reports parity, framing and break errors, and detects overrun.
- Delivers each frame through a one-entry valid/ready holding register to the bus-side consumer.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_bit_sampler.sv | 43 ++++
 rtl/uart_rx_param.sv | 126 ++++++++++++
 tb/tb_uart_rx_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types, parity mode encodings and timing limits
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam int MIN_CPB = 4;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: input synchroniser, per-bit counter and 3-sample majority vote
// Ports: i_Clock/i_Reset; rx_serial raw line; hold keeps the counter at 0 (idle);
// cpb clamped clocks per bit; line synchronised level; bit_done strobes at the
// decision point with bit_value; bit_end strobes on the last cycle of a bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             rx_serial,
    input  logic             hold,
    input  logic [CNT_W-1:0] cpb,
    output logic             line,
    output logic             bit_done,
    output logic             bit_value,
    output logic             bit_end
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt, half;
    logic s0, s1;
    assign half      = (cpb - ONE) >> 1;
    assign line      = sync[SYNC_STAGES-1];
    assign bit_done  = !hold && cnt == half + ONE;
    assign bit_end   = !hold && cnt == cpb - ONE;
    assign bit_value = maj3(s0, s1, line);
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync <= '1;
            cnt  <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_serial};
            cnt  <= (hold || bit_end) ? '0 : cnt + ONE;
            if (cnt == half - ONE) s0 <= line;
            if (cnt == half) s1 <= line;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with parity, stop checks and a valid/ready holding register
// Ports: i_Clock/i_Reset; i_Rx_Serial line; i_Clks_Per_Bit, i_Parity_Mode, i_Two_Stop
// configuration latched at frame start; i_Rx_Ready/o_Rx_Valid handshake with
// o_Rx_Data, o_Parity_Err, o_Frame_Err; o_Break/o_Overrun pulses; o_Busy not idle.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    state_t state, next_state;
    logic line, bit_done, bit_value, bit_end;
    logic [CNT_W-1:0] cpb_q, cpb_in;
    logic [1:0] par_q;
    logic two_q, par_bad, par_bit, frm_q;
    logic [3:0] idx;
    logic [DATA_BITS-1:0] shreg;
    logic par_en, last_data, last_stop, start_frame, complete, frm_final, brk_final, load;
    assign cpb_in    = i_Clks_Per_Bit < CNT_W'(MIN_CPB) ? CNT_W'(MIN_CPB) : i_Clks_Per_Bit;
    assign par_en    = par_q == PAR_EVEN || par_q == PAR_ODD;
    assign last_data = idx == 4'(DATA_BITS - 1);
    assign last_stop = !two_q || idx == 4'd1;
    // Completion happens while the last stop bit is being decided, so its vote is folded in here.
    assign frm_final = frm_q | !bit_value;
    // On the second stop bit, frm_q can only have been set by the first stop bit.
    assign brk_final = shreg == '0 && !par_bit && (idx == 4'd0 ? !bit_value : frm_q);
    assign load      = complete && (!o_Rx_Valid || i_Rx_Ready);
    uart_bit_sampler #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .rx_serial (i_Rx_Serial),
        .hold      (state == IDLE),
        .cpb       (cpb_q),
        .line      (line),
        .bit_done  (bit_done),
        .bit_value (bit_value),
        .bit_end   (bit_end)
    );
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!line) next_state = START;
            START:   if (bit_done && bit_value) next_state = IDLE;
                     else if (bit_end) next_state = DATA;
            DATA:    if (bit_end && last_data) next_state = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_done && last_stop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        o_Busy      = state != IDLE;
        start_frame = state == IDLE && !line;
        complete    = state == STOP && bit_done && last_stop;
    end
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cpb_q   <= CNT_W'(MIN_CPB);
            par_q   <= PAR_NONE;
            two_q   <= 1'b0;
            par_bad <= 1'b0;
            par_bit <= 1'b0;
            frm_q   <= 1'b0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            if (start_frame) begin
                cpb_q   <= cpb_in;
                par_q   <= i_Parity_Mode;
                two_q   <= i_Two_Stop;
                par_bad <= 1'b0;
                par_bit <= 1'b0;
                frm_q   <= 1'b0;
                idx     <= '0;
            end
            if (bit_end) idx <= next_state != state ? '0 : idx + 4'd1;
            if (state == DATA && bit_done) shreg <= {bit_value, shreg[DATA_BITS-1:1]};
            if (state == PARITY && bit_done) begin
                par_bit <= bit_value;
                par_bad <= ^shreg ^ bit_value ^ (par_q == PAR_ODD);
            end
            if (state == STOP && bit_done && !bit_value) frm_q <= 1'b1;
        end
    end
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Rx_Valid   <= 1'b0;
            o_Rx_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Overrun <= complete && !load;
            o_Break   <= complete && brk_final;
            if (load) begin
                o_Rx_Valid   <= 1'b1;
                o_Rx_Data    <= shreg;
                o_Parity_Err <= par_bad;
                o_Frame_Err  <= frm_final;
            end else if (o_Rx_Valid && i_Rx_Ready) begin
                o_Rx_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param
module tb_uart_rx_param;
    logic i_Clock = 1'b0;
    logic i_Reset, i_Rx_Serial, i_Two_Stop, i_Rx_Ready;
    logic [15:0] i_Clks_Per_Bit;
    logic [1:0] i_Parity_Mode;
    logic o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun, o_Busy;
    logic [7:0] o_Rx_Data;
    int checks = 0, errors = 0, brk_cnt = 0, ovr_cnt = 0, b0, o0;
    uart_rx_param #(.DATA_BITS(8), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Rx_Serial    (i_Rx_Serial),
        .i_Clks_Per_Bit (i_Clks_Per_Bit),
        .i_Parity_Mode  (i_Parity_Mode),
        .i_Two_Stop     (i_Two_Stop),
        .i_Rx_Ready     (i_Rx_Ready),
        .o_Rx_Valid     (o_Rx_Valid),
        .o_Rx_Data      (o_Rx_Data),
        .o_Parity_Err   (o_Parity_Err),
        .o_Frame_Err    (o_Frame_Err),
        .o_Break        (o_Break),
        .o_Overrun      (o_Overrun),
        .o_Busy         (o_Busy)
    );
    always #5 i_Clock = ~i_Clock;
    always @(negedge i_Clock) begin
        if (o_Break) brk_cnt++;
        if (o_Overrun) ovr_cnt++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic bitx(input logic v, input int cpb, input int g);
        for (int c = 0; c < cpb; c++) begin
            i_Rx_Serial = (c == g) ? ~v : v;
            @(negedge i_Clock);
        end
    endtask
    task automatic frame(input logic [7:0] d, input int cpb, input int par,
                         input logic s1, input logic s2, input bit two, input int g);
        bitx(1'b0, cpb, -1);
        for (int i = 0; i < 8; i++) bitx(d[i], cpb, g);
        if (par >= 0) bitx(par[0], cpb, -1);
        bitx(s1, cpb, -1);
        if (two) bitx(s2, cpb, -1);
        i_Rx_Serial = 1'b1;
    endtask
    task automatic idle(input int n);
        i_Rx_Serial = 1'b1;
        repeat (n) @(negedge i_Clock);
    endtask
    task automatic take(input logic [7:0] d, input logic pe, input logic fe, input string tag);
        chk({tag, "_valid"}, 32'(o_Rx_Valid), 32'd1);
        chk({tag, "_data"}, 32'(o_Rx_Data), 32'(d));
        chk({tag, "_perr"}, 32'(o_Parity_Err), 32'(pe));
        chk({tag, "_ferr"}, 32'(o_Frame_Err), 32'(fe));
        i_Rx_Ready = 1'b1;
        @(negedge i_Clock);
        i_Rx_Ready = 1'b0;
        chk({tag, "_drop"}, 32'(o_Rx_Valid), 32'd0);
    endtask
    initial begin
        i_Reset = 1'b1; i_Rx_Serial = 1'b1; i_Rx_Ready = 1'b0;
        i_Clks_Per_Bit = 16'd16; i_Parity_Mode = 2'b00; i_Two_Stop = 1'b0;
        repeat (3) @(negedge i_Clock);
        chk("rst_valid", 32'(o_Rx_Valid), 32'd0);
        chk("rst_data", 32'(o_Rx_Data), 32'd0);
        chk("rst_flags", 32'({o_Parity_Err, o_Frame_Err, o_Break, o_Overrun, o_Busy}), 32'd0);
        i_Reset = 1'b0;
        idle(4);
        // basic frame with completion-latency probe
        fork
            frame(8'hA5, 16, -1, 1'b1, 1'b1, 1'b0, -1);
            begin
                repeat (4 + 9 * 16 + 7) @(negedge i_Clock);
                chk("lat_before", 32'(o_Rx_Valid), 32'd0);
                @(negedge i_Clock);
                chk("lat_after", 32'(o_Rx_Valid), 32'd1);
            end
        join
        idle(32);
        take(8'hA5, 1'b0, 1'b0, "basic");
        // parity even / odd
        i_Clks_Per_Bit = 16'd10; i_Parity_Mode = 2'b01;
        frame(8'h37, 10, 1, 1'b1, 1'b1, 1'b0, -1); idle(30); take(8'h37, 1'b0, 1'b0, "even_ok");
        frame(8'h37, 10, 0, 1'b1, 1'b1, 1'b0, -1); idle(30); take(8'h37, 1'b1, 1'b0, "even_bad");
        i_Parity_Mode = 2'b10;
        frame(8'h37, 10, 0, 1'b1, 1'b1, 1'b0, -1); idle(30); take(8'h37, 1'b0, 1'b0, "odd_ok");
        frame(8'h37, 10, 1, 1'b1, 1'b1, 1'b0, -1); idle(30); take(8'h37, 1'b1, 1'b0, "odd_bad");
        // false start and mid-bit glitches
        i_Parity_Mode = 2'b00; i_Clks_Per_Bit = 16'd16;
        i_Rx_Serial = 1'b0;
        repeat (3) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (4) @(negedge i_Clock);
        chk("false_start_busy", 32'(o_Busy), 32'd1);
        idle(40);
        chk("false_start_idle", 32'(o_Busy), 32'd0);
        chk("false_start_novalid", 32'(o_Rx_Valid), 32'd0);
        frame(8'h5A, 16, -1, 1'b1, 1'b1, 1'b0, 8); idle(40); take(8'h5A, 1'b0, 1'b0, "glitch");
        // two stop bits
        i_Clks_Per_Bit = 16'd8; i_Two_Stop = 1'b1;
        frame(8'h3C, 8, -1, 1'b1, 1'b0, 1'b1, -1); idle(30); take(8'h3C, 1'b0, 1'b1, "stop2_bad");
        frame(8'hC3, 8, -1, 1'b1, 1'b1, 1'b1, -1); idle(30); take(8'hC3, 1'b0, 1'b0, "stop2_ok");
        i_Two_Stop = 1'b0;
        // break: 12 bit times low
        b0 = brk_cnt;
        i_Rx_Serial = 1'b0;
        repeat (96) @(negedge i_Clock);
        idle(200);
        chk("break_pulses", 32'(brk_cnt - b0), 32'd1);
        take(8'h00, 1'b0, 1'b1, "break");
        // overrun on back-to-back frames
        o0 = ovr_cnt;
        frame(8'h11, 8, -1, 1'b1, 1'b1, 1'b0, -1);
        frame(8'h22, 8, -1, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
        take(8'h11, 1'b0, 1'b0, "overrun");
        // ready only in the completion cycle of the second frame
        o0 = ovr_cnt;
        frame(8'h11, 8, -1, 1'b1, 1'b1, 1'b0, -1);
        fork
            frame(8'h22, 8, -1, 1'b1, 1'b1, 1'b0, -1);
            begin
                repeat (4 + 9 * 8 + 3) @(negedge i_Clock);
                i_Rx_Ready = 1'b1;
                @(negedge i_Clock);
                i_Rx_Ready = 1'b0;
            end
        join
        idle(30);
        chk("exact_ready_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        take(8'h22, 1'b0, 1'b0, "exact_ready");
        // reset during data bit 3 with a frame held
        frame(8'hA5, 8, -1, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("rst_mid_held", 32'(o_Rx_Valid), 32'd1);
        i_Rx_Serial = 1'b0;
        repeat (8) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (28) @(negedge i_Clock);
        chk("rst_mid_busy", 32'(o_Busy), 32'd1);
        i_Reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(o_Rx_Valid), 32'd0);
        chk("rst_mid_data", 32'(o_Rx_Data), 32'd0);
        chk("rst_mid_flags", 32'({o_Parity_Err, o_Frame_Err, o_Break, o_Overrun, o_Busy}), 32'd0);
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
        idle(100);
        chk("rst_after_idle", 32'({o_Rx_Valid, o_Busy}), 32'd0);
        // clocks-per-bit changed mid-frame
        fork
            frame(8'hC3, 8, -1, 1'b1, 1'b1, 1'b0, -1);
            begin
                repeat (10) @(negedge i_Clock);
                i_Clks_Per_Bit = 16'd16;
            end
        join
        idle(30);
        take(8'hC3, 1'b0, 1'b0, "cfg_old");
        frame(8'h3C, 16, -1, 1'b1, 1'b1, 1'b0, -1); idle(40); take(8'h3C, 1'b0, 1'b0, "cfg_new");
        // CPB below minimum clamps to 4; parity mode 11 means none
        i_Clks_Per_Bit = 16'd2; i_Parity_Mode = 2'b11;
        frame(8'h96, 4, -1, 1'b1, 1'b1, 1'b0, -1); idle(20); take(8'h96, 1'b0, 1'b0, "cpb2");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
